// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write bus of the boot-time program loader.
// The slave modport is the loader; the master modport is its environment.
interface prog_loader_if #(
    parameter int unsigned ADDR_BITS  = 10,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [ADDR_BITS-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_we;
    logic                  cpu_hold;
    logic                  done;
    logic                  error;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_addr, mem_data, mem_we, cpu_hold, done, error
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_addr, mem_data, mem_we, cpu_hold, done, error
    );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: assembles big-endian words from a byte stream and writes them to
// program memory from address 0. Define PROG_LOADER_CHECKSUM_EN for the trailing XOR checksum.
module prog_loader #(
    parameter int unsigned ADDR_BITS  = 10,
    parameter int unsigned DATA_WIDTH = 16
) (
    input logic          clk,
    input logic          reset,
    prog_loader_if.slave bus
);

    localparam int unsigned Capacity = 32'd1 << ADDR_BITS;

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        StHdrHi, StHdrLo, StDataHi, StDataLo, StFinish, StDone, StErr, StCksum
    } state_e;
    localparam state_e StAfterData = StCksum;
`else
    typedef enum logic [2:0] {
        StHdrHi, StHdrLo, StDataHi, StDataLo, StFinish, StDone, StErr
    } state_e;
    localparam state_e StAfterData = StFinish;
`endif

    state_e                state_q, state_d;
    logic                  rx_ready;
    logic                  accept;
    logic [15:0]           hdr_count;
    logic [7:0]            count_hi_q;
    logic [7:0]            word_hi_q;
    logic [15:0]           remain_q;
    logic [ADDR_BITS-1:0]  next_addr_q;
    logic [ADDR_BITS-1:0]  mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic                  mem_we_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q;
`endif

    assign rx_ready  = !(state_q inside {StFinish, StDone, StErr});
    assign accept    = bus.rx_valid && rx_ready;
    assign hdr_count = {count_hi_q, bus.rx_data};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHdrHi: if (accept) state_d = StHdrLo;
            StHdrLo: begin
                if (accept) begin
                    if (hdr_count == 16'd0) begin
                        state_d = StAfterData;
                    end else if ({16'd0, hdr_count} > Capacity) begin
                        state_d = StErr;
                    end else begin
                        state_d = StDataHi;
                    end
                end
            end
            StDataHi: if (accept) state_d = StDataLo;
            StDataLo: if (accept) state_d = (remain_q == 16'd1) ? StAfterData : StDataHi;
`ifdef PROG_LOADER_CHECKSUM_EN
            StCksum:  if (accept) state_d = (bus.rx_data == csum_q) ? StDone : StErr;
`endif
            StFinish: state_d = StDone;
            default:  state_d = state_q;  // StDone and StErr are terminal
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StHdrHi;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_hi_q  <= 8'd0;
            word_hi_q   <= 8'd0;
            remain_q    <= 16'd0;
            next_addr_q <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            if (accept && state_q == StHdrHi) count_hi_q <= bus.rx_data;
            if (accept && state_q == StHdrLo) remain_q <= hdr_count;
            if (accept && state_q == StDataHi) word_hi_q <= bus.rx_data;
            if (accept && state_q == StDataLo) begin
                mem_we_q    <= 1'b1;
                mem_addr_q  <= next_addr_q;
                mem_data_q  <= {word_hi_q, bus.rx_data};
                next_addr_q <= next_addr_q + ADDR_BITS'(1);
                remain_q    <= remain_q - 16'd1;
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Accumulates count and data bytes; the checksum byte itself is excluded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_q <= 8'd0;
        end else if (accept && state_q != StCksum) begin
            csum_q <= csum_q ^ bus.rx_data;
        end
    end
`endif

    assign bus.rx_ready = rx_ready;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.cpu_hold = (state_q != StDone);
    assign bus.done     = (state_q == StDone);
    assign bus.error    = (state_q == StErr);

endmodule
